// File: rtl/strobe_pkg.sv
// Shared timebase helpers: converts a period in nanoseconds to clock ticks and sizes the counter.
// Every timer block that derives its reload value from a clock frequency imports this package.
package strobe_pkg;

  localparam longint unsigned NS_PER_S = 64'd1_000_000_000;
  localparam longint unsigned HALF_NS  = 64'd500_000_000;

  // Rounded tick count before clamping; all arithmetic stays in 64 bits so 1e9 x 1e9 cannot overflow.
  function automatic longint unsigned ns_to_ticks_raw(input longint unsigned clock_hz,
                                                      input longint unsigned period_ns);
    return (period_ns * clock_hz + HALF_NS) / NS_PER_S;
  endfunction

  function automatic longint unsigned ns_to_ticks(input longint unsigned clock_hz,
                                                  input longint unsigned period_ns);
    longint unsigned ticks;
    ticks = ns_to_ticks_raw(clock_hz, period_ns);
    return (ticks == 0) ? 64'd1 : ticks;
  endfunction

  function automatic int unsigned counter_width(input longint unsigned reload);
    return (reload == 0) ? 1 : $clog2(reload + 1);
  endfunction

endpackage

// File: rtl/strobe_generator_if.sv
// Enable/strobe pair between a strobe generator and the peripheral it paces.
// The master owns the enable and consumes the strobe; the generator is the slave.
interface strobe_generator_if;
  logic Enable_i;
  logic Strobe_o;

  modport master (output Enable_i, input Strobe_o);
  modport slave  (input Enable_i, output Strobe_o);
endinterface

// File: rtl/strobe_generator.sv
// Periodic single-cycle strobe: fires once every PERIOD_NS nanoseconds while enabled.
// A down-counter reloads at zero, so it never wraps; dropping enable discards the phase.
module strobe_generator
  import strobe_pkg::*;
#(
  parameter longint unsigned CLOCK_HZ  = 14_000_000,
  parameter longint unsigned PERIOD_NS = 500
) (
  input  logic               Clock,
  input  logic               Reset,
  strobe_generator_if.slave  bus
);

  localparam real             CLOCK_PERIOD_NS = 1.0e9 / real'(CLOCK_HZ);
  localparam longint unsigned RAW_TICKS       = ns_to_ticks_raw(CLOCK_HZ, PERIOD_NS);
  localparam longint unsigned DELAY_TICKS     = ns_to_ticks(CLOCK_HZ, PERIOD_NS);
  localparam longint unsigned DELAY           = DELAY_TICKS - 1;
  localparam int unsigned     WIDTH           = counter_width(DELAY);

  localparam logic [WIDTH-1:0] DELAY_LOAD = WIDTH'(DELAY);

  if (CLOCK_HZ < 1 || PERIOD_NS < 1) begin : g_bad_param
    $error("strobe_generator: CLOCK_HZ and PERIOD_NS must both be >= 1");
  end

  if (RAW_TICKS == 0) begin : g_clamped
    $warning("strobe_generator: period rounds to 0 ticks, clamped to 1");
  end

  logic [WIDTH-1:0] counter;
  logic             strobe;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      counter <= DELAY_LOAD;
      strobe  <= 1'b0;
    end else if (!bus.Enable_i) begin
      counter <= DELAY_LOAD;
      strobe  <= 1'b0;
    end else if (counter == '0) begin
      counter <= DELAY_LOAD;
      strobe  <= 1'b1;
    end else begin
      counter <= counter - 1'b1;
      strobe  <= 1'b0;
    end
  end

  assign bus.Strobe_o = strobe;

endmodule

// File: tb/tb_strobe_generator.sv
// Directed self-checking bench for strobe_generator: default timing plus two parameter corners.
// Cycle counts are derived from 14 MHz / 500 ns = 7 ticks per strobe.
module tb_strobe_generator;

  logic clk;
  logic rst_n;
  int   n_tests  = 0;
  int   n_failed = 0;

  strobe_generator_if bus ();
  strobe_generator_if bus_fast ();
  strobe_generator_if bus_big ();

  strobe_generator dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  strobe_generator #(.CLOCK_HZ(100_000_000), .PERIOD_NS(10)) dut_fast (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus_fast.slave)
  );

  strobe_generator #(.CLOCK_HZ(1_000_000_000), .PERIOD_NS(1_000_000_000)) dut_big (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus_big.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe must stay low for n-1 cycles and be high for exactly the n-th.
  task automatic expect_strobe_at(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      tick();
      check(tag, 64'(bus.Strobe_o), 64'(i == n));
    end
  endtask

  initial begin
    real period_err;

    rst_n            = 1'b0;
    bus.Enable_i     = 1'b1;
    bus_fast.Enable_i = 1'b0;
    bus_big.Enable_i  = 1'b0;

    $display("[TB] CLOCK_PERIOD_NS=%f DELAY_TICKS=%0d DELAY=%0d WIDTH=%0d",
             dut.CLOCK_PERIOD_NS, dut.DELAY_TICKS, dut.DELAY, dut.WIDTH);
    period_err = dut.CLOCK_PERIOD_NS - 71.428571;
    if (period_err < 0.0) period_err = -period_err;
    check("clock_period_ns", 64'(period_err < 1.0e-5), 64'd1);
    check("delay_ticks", 64'(dut.DELAY_TICKS), 64'd7);
    check("delay", 64'(dut.DELAY), 64'd6);
    check("width", 64'(dut.WIDTH), 64'd3);

    // Reset held for 3 cycles with enable high.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_strobe_low", 64'(bus.Strobe_o), 64'd0);
    end
    check("reset_counter", 64'(dut.counter), 64'd6);

    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) expect_strobe_at("first_four_strobes", 7);

    // Enable low for 14 cycles mid-run, then a full interval after re-enable.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pre_disable", 64'(bus.Strobe_o), 64'd0);
    end
    bus.Enable_i = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      check("disabled_no_strobe", 64'(bus.Strobe_o), 64'd0);
    end
    check("disabled_counter", 64'(dut.counter), 64'd6);
    bus.Enable_i = 1'b1;
    expect_strobe_at("reenable_strobe", 7);

    // Drop enable on the cycle where the counter sits at zero.
    for (int i = 0; i < 6; i++) begin
      tick();
      check("count_to_zero", 64'(bus.Strobe_o), 64'd0);
    end
    check("counter_at_zero", 64'(dut.counter), 64'd0);
    bus.Enable_i = 1'b0;
    tick();
    check("drop_at_zero_strobe", 64'(bus.Strobe_o), 64'd0);
    check("drop_at_zero_reload", 64'(dut.counter), 64'd6);
    bus.Enable_i = 1'b1;
    expect_strobe_at("after_drop_strobe", 7);

    // Reset while the counter holds 2.
    for (int i = 0; i < 4; i++) tick();
    check("counter_at_two", 64'(dut.counter), 64'd2);
    rst_n = 1'b0;
    tick();
    check("midcount_reset_strobe", 64'(bus.Strobe_o), 64'd0);
    check("midcount_reset_counter", 64'(dut.counter), 64'd6);
    rst_n = 1'b1;
    expect_strobe_at("after_reset_strobe", 7);

    // One-tick period: strobe continuously high while enabled.
    check("fast_delay_ticks", 64'(dut_fast.DELAY_TICKS), 64'd1);
    check("fast_width", 64'(dut_fast.WIDTH), 64'd1);
    check("fast_idle_low", 64'(bus_fast.Strobe_o), 64'd0);
    bus_fast.Enable_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fast_continuous_high", 64'(bus_fast.Strobe_o), 64'd1);
    end
    bus_fast.Enable_i = 1'b0;
    tick();
    check("fast_disabled_low", 64'(bus_fast.Strobe_o), 64'd0);

    // One-second period at 1 GHz: 64-bit tick math must not overflow.
    check("big_delay_ticks", 64'(dut_big.DELAY_TICKS), 64'd1_000_000_000);
    check("big_width", 64'(dut_big.WIDTH), 64'd30);
    check("big_reload", 64'(dut_big.counter), 64'd999_999_999);
    bus_big.Enable_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("big_countdown", 64'(dut_big.counter), 64'd999_999_996);
    check("big_no_strobe", 64'(bus_big.Strobe_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
